// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS-lite sequencer:
// opcodes, functs, ALU ops, state codes and decode classes.
package mc_ctrl_fsm_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;

  localparam logic [4:0] ALUOp_NOP   = 5'd0;
  localparam logic [4:0] ALUOp_ADDU  = 5'd1;
  localparam logic [4:0] ALUOp_SUBU  = 5'd2;
  localparam logic [4:0] ALUOp_MULTU = 5'd3;
  localparam logic [4:0] ALUOp_AND   = 5'd4;
  localparam logic [4:0] ALUOp_OR    = 5'd5;
  localparam logic [4:0] ALUOp_XOR   = 5'd6;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EXE = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4,
    ST_BR  = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CL_RTYPE,
    CL_ORI,
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_J,
    CL_ILLEGAL
  } op_class_e;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       pc_wr;
    logic       ir_wr;
    logic       jmp_ctl;
    logic       branch;
    logic       a3_src;
    logic       wd_src;
    logic       rf_wr;
    logic       dm_rd;
    logic       dm_wr;
    logic       alu_b;
    logic [4:0] alu_ctl;
    logic       retire;
  } ctrl_t;

  // ALUOp_NOP doubles as "unsupported funct"
  function automatic logic [4:0] rtype_alu(input logic [5:0] fn);
    logic [4:0] r;
    unique case (fn)
      FN_ADDU:  r = ALUOp_ADDU;
      FN_SUBU:  r = ALUOp_SUBU;
      FN_MULTU: r = ALUOp_MULTU;
      FN_AND:   r = ALUOp_AND;
      FN_OR:    r = ALUOp_OR;
      FN_XOR:   r = ALUOp_XOR;
      default:  r = ALUOp_NOP;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_op_decode.sv
// Combinational op/funct decoder: instruction class and ALU op.
module mc_op_decode
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output op_class_e  op_class,
  output logic [4:0] alu_ctl
);

  logic [4:0] r_alu;

  always_comb begin
    r_alu    = rtype_alu(funct);
    op_class = CL_ILLEGAL;
    alu_ctl  = ALUOp_NOP;
    unique case (1'b1)
      (op == OP_RTYPE): begin
        if (r_alu != ALUOp_NOP) begin
          op_class = CL_RTYPE;
          alu_ctl  = r_alu;
        end
      end
      (op == OP_ORI): begin
        op_class = CL_ORI;
        alu_ctl  = ALUOp_OR;
      end
      (op == OP_LW): begin
        op_class = CL_LW;
        alu_ctl  = ALUOp_ADDU;
      end
      (op == OP_SW): begin
        op_class = CL_SW;
        alu_ctl  = ALUOp_ADDU;
      end
      (op == OP_BEQ): begin
        op_class = CL_BEQ;
        alu_ctl  = ALUOp_SUBU;
      end
      (op == OP_J): op_class = CL_J;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle sequencer: IF/ID/EXE/MEM/WB/BR with a shared
// memory port, wait-state timeout, hold and sticky error flags.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAIT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       hold,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       PCWr,
  output logic       IRWr,
  output logic       JMPCTL,
  output logic       Branch,
  output logic       A3_Src,
  output logic       WD_Src,
  output logic       RFWr,
  output logic       DMRd,
  output logic       DMWr,
  output logic       ALU_B_Select,
  output logic [4:0] ALUCtl,
  output logic [2:0] state,
  output logic       retire,
  output logic       illegal,
  output logic       bus_err
);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [5:0]        op_q, op_d;
  logic [5:0]        fn_q, fn_d;
  logic              illegal_q, illegal_d;
  logic              bus_err_q, bus_err_d;

  logic [5:0] dec_op, dec_fn;
  op_class_e  cls;
  logic [4:0] dec_alu;
  logic       waiting, timeout, go, b_imm;
  ctrl_t      ctl, ctl_o;

  // ID decides on the live IR; later states use the latched copy
  assign dec_op = (state_q == ST_ID) ? Op : op_q;
  assign dec_fn = (state_q == ST_ID) ? Funct : fn_q;

  mc_op_decode u_dec (
    .op       (dec_op),
    .funct    (dec_fn),
    .op_class (cls),
    .alu_ctl  (dec_alu)
  );

  assign go      = ~hold;
  assign b_imm   = (cls == CL_ORI) || (cls == CL_LW) ||
                   (cls == CL_SW);
  assign waiting = ((state_q == ST_IF) || (state_q == ST_MEM))
                   && !mem_ready;
  assign timeout = waiting &&
                   (cnt_q == WAIT_W'(MEM_WAIT_MAX - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    fn_d      = fn_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    if (go) begin
      unique case (state_q)
        ST_IF: begin
          if (mem_ready) state_d = ST_ID;
          else if (timeout) bus_err_d = 1'b1;
        end
        ST_ID: begin
          op_d = Op;
          fn_d = Funct;
          unique case (cls)
            CL_J: state_d = ST_IF;
            CL_ILLEGAL: begin
              state_d   = ST_IF;
              illegal_d = 1'b1;
            end
            default: state_d = ST_EXE;
          endcase
        end
        ST_EXE: begin
          unique case (cls)
            CL_RTYPE, CL_ORI: state_d = ST_WB;
            CL_LW, CL_SW:     state_d = ST_MEM;
            CL_BEQ:           state_d = ST_BR;
            default:          state_d = ST_IF;
          endcase
        end
        ST_MEM: begin
          if (mem_ready) begin
            state_d = (cls == CL_LW) ? ST_WB : ST_IF;
          end else if (timeout) begin
            state_d   = ST_IF;
            bus_err_d = 1'b1;
          end
        end
        default: state_d = ST_IF;
      endcase
      if (waiting && !timeout) cnt_d = cnt_q + 1'b1;
      else cnt_d = '0;
    end
  end

  always_comb begin
    ctl = '0;
    unique case (state_q)
      ST_IF: begin
        ctl.mem_req = go;
        ctl.jmp_ctl = 1'b1;
        ctl.ir_wr   = go && mem_ready;
        ctl.pc_wr   = go && mem_ready;
      end
      ST_ID: begin
        if (cls == CL_J) begin
          ctl.pc_wr  = go;
          ctl.retire = go;
        end else if (cls == CL_ILLEGAL) begin
          ctl.retire = go;
        end
      end
      ST_EXE: begin
        ctl.alu_ctl = dec_alu;
        ctl.alu_b   = b_imm;
      end
      ST_MEM: begin
        ctl.alu_ctl = dec_alu;
        ctl.alu_b   = b_imm;
        ctl.mem_req = go;
        ctl.iord    = 1'b1;
        ctl.dm_rd   = go && (cls == CL_LW);
        ctl.dm_wr   = go && (cls == CL_SW);
      end
      ST_WB: begin
        ctl.alu_ctl = dec_alu;
        ctl.alu_b   = b_imm;
        ctl.rf_wr   = go;
        ctl.retire  = go;
        ctl.a3_src  = (cls == CL_RTYPE);
        ctl.wd_src  = (cls == CL_LW);
      end
      ST_BR: begin
        ctl.alu_ctl = ALUOp_SUBU;
        ctl.branch  = go;
        ctl.retire  = go;
      end
      default: ;
    endcase
  end

  // reset low kills every strobe combinationally, no edge needed
  assign ctl_o = rst ? ctl : '0;

  assign {mem_req, IorD, PCWr, IRWr, JMPCTL, Branch,
          A3_Src, WD_Src, RFWr, DMRd, DMWr,
          ALU_B_Select, ALUCtl, retire} = ctl_o;

  assign state   = state_q;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IF;
      cnt_q     <= '0;
      op_q      <= '0;
      fn_q      <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      fn_q      <= fn_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Cycle-exact scoreboard bench for mc_ctrl_fsm, MEM_WAIT_MAX=4.
module tb_mc_ctrl_fsm;
  import mc_ctrl_fsm_pkg::*;

  logic       clk, rst, hold, mem_ready;
  logic [5:0] Op, Funct;
  logic       mem_req, IorD, PCWr, IRWr, JMPCTL, Branch;
  logic       A3_Src, WD_Src, RFWr, DMRd, DMWr, ALU_B_Select;
  logic [4:0] ALUCtl;
  logic [2:0] state;
  logic       retire, illegal, bus_err;

  mc_ctrl_fsm #(.MEM_WAIT_MAX(4), .WAIT_W(8)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct),
    .hold(hold), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .PCWr(PCWr),
    .IRWr(IRWr), .JMPCTL(JMPCTL), .Branch(Branch),
    .A3_Src(A3_Src), .WD_Src(WD_Src), .RFWr(RFWr),
    .DMRd(DMRd), .DMWr(DMWr),
    .ALU_B_Select(ALU_B_Select), .ALUCtl(ALUCtl),
    .state(state), .retire(retire),
    .illegal(illegal), .bus_err(bus_err)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       mem_req, iord, pcwr, irwr, jmp, branch;
    logic       a3, wd, rfwr, dmrd, dmwr, bsel;
    logic [4:0] alu;
    logic       retire, illegal, berr;
  } obs_t;

  obs_t obs;
  assign obs = {state, mem_req, IorD, PCWr, IRWr, JMPCTL,
                Branch, A3_Src, WD_Src, RFWr, DMRd, DMWr,
                ALU_B_Select, ALUCtl, retire, illegal, bus_err};

  int    npass = 0;
  int    ntot  = 0;
  bit    ill_exp = 0;
  bit    berr_exp = 0;
  obs_t  sb_q[$];
  string tag_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, passed %0d of %0d",
             npass, ntot);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input obs_t got,
                     input obs_t exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h required %h", tag, got, exp);
  endtask

  task automatic cyc(input string tag, input obs_t e);
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    chk(tag_q.pop_front(), obs, sb_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t z();
    obs_t e;
    e = '0;
    e.illegal = ill_exp;
    e.berr = berr_exp;
    return e;
  endfunction

  function automatic obs_t s_if(input bit r);
    obs_t e = z();
    e.mem_req = 1; e.jmp = 1; e.irwr = r; e.pcwr = r;
    return e;
  endfunction

  function automatic obs_t s_id();
    obs_t e = z();
    e.st = 3'd1;
    return e;
  endfunction

  function automatic obs_t s_ex(input logic [4:0] a, input bit b);
    obs_t e = z();
    e.st = 3'd2; e.alu = a; e.bsel = b;
    return e;
  endfunction

  function automatic obs_t s_mem(input logic [4:0] a, input bit b,
                                 input bit rd, input bit wr);
    obs_t e = z();
    e.st = 3'd3; e.alu = a; e.bsel = b;
    e.mem_req = 1; e.iord = 1; e.dmrd = rd; e.dmwr = wr;
    return e;
  endfunction

  function automatic obs_t s_wb(input logic [4:0] a, input bit b,
                                input bit a3, input bit wd);
    obs_t e = z();
    e.st = 3'd4; e.alu = a; e.bsel = b;
    e.rfwr = 1; e.retire = 1; e.a3 = a3; e.wd = wd;
    return e;
  endfunction

  function automatic obs_t s_br();
    obs_t e = z();
    e.st = 3'd5; e.alu = ALUOp_SUBU; e.branch = 1; e.retire = 1;
    return e;
  endfunction

  task automatic fetch(input int waits);
    mem_ready = 1'b0;
    for (int i = 0; i < waits; i++) cyc("if_wait", s_if(0));
    mem_ready = 1'b1;
    cyc("if_done", s_if(1));
  endtask

  logic [5:0] fns[6];
  logic [4:0] alus[6];
  obs_t e;

  initial begin
    fns  = '{FN_ADDU, FN_SUBU, FN_MULTU, FN_AND, FN_OR, FN_XOR};
    alus = '{ALUOp_ADDU, ALUOp_SUBU, ALUOp_MULTU,
             ALUOp_AND, ALUOp_OR, ALUOp_XOR};
    rst = 0; hold = 0; mem_ready = 1; Op = 0; Funct = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", obs, '0);
    rst = 1;

    Op = OP_RTYPE; Funct = FN_ADDU;
    fetch(0);
    cyc("addu_id", s_id());
    cyc("addu_ex", s_ex(ALUOp_ADDU, 0));
    cyc("addu_wb", s_wb(ALUOp_ADDU, 0, 1, 0));

    for (int i = 0; i < 6; i++) begin
      Op = OP_RTYPE; Funct = fns[i];
      fetch(i % 3);
      cyc("r_id", s_id());
      cyc("r_ex", s_ex(alus[i], 0));
      cyc("r_wb", s_wb(alus[i], 0, 1, 0));
    end

    Op = OP_ORI; Funct = 6'h2a;
    fetch(2);
    cyc("ori_id", s_id());
    cyc("ori_ex", s_ex(ALUOp_OR, 1));
    cyc("ori_wb", s_wb(ALUOp_OR, 1, 0, 0));

    Op = OP_LW;
    fetch(0);
    cyc("lw_id", s_id());
    cyc("lw_ex", s_ex(ALUOp_ADDU, 1));
    mem_ready = 0;
    for (int i = 0; i < 3; i++)
      cyc("lw_mem_wait", s_mem(ALUOp_ADDU, 1, 1, 0));
    mem_ready = 1;
    cyc("lw_mem_last", s_mem(ALUOp_ADDU, 1, 1, 0));
    cyc("lw_wb", s_wb(ALUOp_ADDU, 1, 0, 1));

    Op = OP_BEQ;
    fetch(0);
    cyc("beq_id", s_id());
    cyc("beq_ex", s_ex(ALUOp_SUBU, 0));
    cyc("beq_br", s_br());

    Op = OP_J;
    fetch(1);
    e = s_id(); e.pcwr = 1; e.retire = 1;
    cyc("j_id", e);

    Op = OP_SW;
    fetch(0);
    cyc("sw_id", s_id());
    cyc("sw_ex", s_ex(ALUOp_ADDU, 1));
    mem_ready = 0;
    for (int i = 0; i < 4; i++)
      cyc("sw_mem_to", s_mem(ALUOp_ADDU, 1, 0, 1));
    berr_exp = 1;
    for (int i = 0; i < 4; i++)
      cyc("if_to", s_if(0));
    Op = OP_J;
    fetch(3);
    e = s_id(); e.pcwr = 1; e.retire = 1;
    cyc("j2_id", e);

    Op = 6'b111111;
    fetch(0);
    e = s_id(); e.retire = 1;
    cyc("ill_id", e);
    ill_exp = 1;
    Op = OP_RTYPE; Funct = 6'b000000;
    fetch(0);
    e = s_id(); e.retire = 1;
    cyc("badfn_id", e);
    Funct = FN_XOR;
    fetch(0);
    cyc("post_ill_id", s_id());
    cyc("post_ill_ex", s_ex(ALUOp_XOR, 0));
    cyc("post_ill_wb", s_wb(ALUOp_XOR, 0, 1, 0));

    Funct = FN_ADDU;
    hold = 1; mem_ready = 1;
    e = s_if(0); e.mem_req = 0;
    cyc("hold_if", e);
    hold = 0;
    fetch(0);
    cyc("h_id", s_id());
    cyc("h_ex", s_ex(ALUOp_ADDU, 0));
    hold = 1;
    e = s_wb(ALUOp_ADDU, 0, 1, 0); e.rfwr = 0; e.retire = 0;
    cyc("hold_wb", e);
    cyc("hold_wb2", e);
    hold = 0;
    cyc("h_wb", s_wb(ALUOp_ADDU, 0, 1, 0));

    Op = OP_LW;
    fetch(0);
    cyc("r_lw_id", s_id());
    cyc("r_lw_ex", s_ex(ALUOp_ADDU, 1));
    mem_ready = 0;
    cyc("r_lw_mem", s_mem(ALUOp_ADDU, 1, 1, 0));
    rst = 0;
    #1;
    ill_exp = 0; berr_exp = 0;
    chk("rst_async", obs, z());
    @(posedge clk);
    #1;
    chk("rst_held", obs, '0);
    rst = 1;
    fetch(1);
    cyc("post_rst_id", s_id());

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
